memory_stage: RTL

- Pipeline MEM stage of the RV64 core. Consumes the execute register `dataE` (execute_data_t) and drives the data bus for loads and stores.
- Load data is aligned and extended by msize/mem_unsigned. The stage produces the registered `dataM` (memory_data_t) for writeback.
- Holds the front of the pipe through `mem_busy` while a bus transaction is outstanding.

---
 rtl/memory_stage_pkg.sv | 91 +++++++++
 rtl/memory_stage_align.sv | 53 +++++
 rtl/memory_stage.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/memory_stage_pkg.sv
// Shared types for the RV64 MEM stage: pipeline register layouts, data bus
// request/response records, access sizes and the MEM handshake states.
package memory_stage_pkg;

    localparam int BUS_BYTES_DEFAULT = 8;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2,
        MSIZE8 = 2'd3
    } msize_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } mem_state_t;

    localparam logic [7:0] STROBE_MSIZE1 = 8'h01;
    localparam logic [7:0] STROBE_MSIZE2 = 8'h03;
    localparam logic [7:0] STROBE_MSIZE4 = 8'h0F;
    localparam logic [7:0] STROBE_MSIZE8 = 8'hFF;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [63:0] pc;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic        memtoreg;
        msize_t      msize;
        logic        mem_unsigned;
        logic [63:0] aluout;
        logic [63:0] writedata;
        logic [4:0]  dst;
    } execute_data_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [63:0] pc;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic        memtoreg;
        logic [63:0] aluout;
        logic [63:0] readdata;
        logic [4:0]  dst;
    } memory_data_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    function automatic logic [7:0] size_mask(input msize_t s);
        case (s)
            MSIZE1:  return STROBE_MSIZE1;
            MSIZE2:  return STROBE_MSIZE2;
            MSIZE4:  return STROBE_MSIZE4;
            default: return STROBE_MSIZE8;
        endcase
    endfunction

    function automatic memory_data_t to_mem(input execute_data_t e, input logic [63:0] rd);
        memory_data_t m;
        m.valid    = e.valid;
        m.instr    = e.instr;
        m.pc       = e.pc;
        m.regwrite = e.regwrite;
        m.memread  = e.memread;
        m.memwrite = e.memwrite;
        m.memtoreg = e.memtoreg;
        m.aluout   = e.aluout;
        m.readdata = rd;
        m.dst      = e.dst;
        return m;
    endfunction

endpackage

// File: rtl/memory_stage_align.sv
// Byte-lane alignment for the data bus: store data/strobe placement, load
// lane extraction with sign/zero extension, and natural-alignment check.
module mem_align
    import memory_stage_pkg::*;
#(
    parameter int BUS_BYTES = BUS_BYTES_DEFAULT
) (
    input  msize_t               msize,
    input  logic [2:0]           addr,
    input  logic                 mem_unsigned,
    input  logic [63:0]          writedata,
    input  logic [63:0]          rdata,
    output logic [BUS_BYTES-1:0] strobe,
    output logic [63:0]          wdata_shifted,
    output logic [63:0]          rdata_extended,
    output logic                 aligned
);

    logic [5:0]  bit_shift;
    logic [63:0] lane;

    assign bit_shift     = {addr, 3'b000};
    assign wdata_shifted = writedata << bit_shift;
    assign strobe        = BUS_BYTES'(size_mask(msize)) << addr;
    assign lane          = rdata >> bit_shift;

    always_comb begin
        rdata_extended = lane;
        aligned        = 1'b1;
        case (msize)
            MSIZE1: begin
                rdata_extended = mem_unsigned ? {56'd0, lane[7:0]}
                                              : {{56{lane[7]}}, lane[7:0]};
            end
            MSIZE2: begin
                rdata_extended = mem_unsigned ? {48'd0, lane[15:0]}
                                              : {{48{lane[15]}}, lane[15:0]};
                aligned        = (addr[0] == 1'b0);
            end
            MSIZE4: begin
                rdata_extended = mem_unsigned ? {32'd0, lane[31:0]}
                                              : {{32{lane[31]}}, lane[31:0]};
                aligned        = (addr[1:0] == 2'b00);
            end
            default: begin
                // Doubleword: the whole bus is the value, nothing to extend.
                rdata_extended = lane;
                aligned        = (addr == 3'b000);
            end
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// RV64 MEM stage: issues one data bus transaction per load/store, stalls the
// front of the pipe while it is outstanding, and registers the result in dataM.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int BUS_BYTES = BUS_BYTES_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  execute_data_t dataE,
    input  logic          stallM,
    input  logic          flushM,
    output dbus_req_t     dreq,
    input  dbus_resp_t    dresp,
    output logic          mem_busy,
    output memory_data_t  dataM,
    output logic          misalign
);

    mem_state_t           state_reg, state_next;
    memory_data_t         data_m_reg;
    logic                 misalign_reg;
    logic [63:0]          addr_reg;
    msize_t               size_reg;
    logic [BUS_BYTES-1:0] strobe_reg;
    logic [63:0]          wdata_reg;
    logic                 unsigned_reg;
    memory_data_t         entry_reg;
    memory_data_t         held_reg;

    logic                 memop;
    msize_t               align_size;
    logic [2:0]           align_addr;
    logic                 align_unsigned;
    logic [BUS_BYTES-1:0] strobe;
    logic [63:0]          wdata_shifted;
    logic [63:0]          rdata_extended;
    logic                 aligned;
    memory_data_t         loaded_m;
    memory_data_t         misaligned_m;
    logic                 unused_addr_ok;

    assign memop          = dataE.valid & (dataE.memread | dataE.memwrite);
    assign unused_addr_ok = dresp.addr_ok;

    // One aligner serves both directions: issue-side fields come from dataE
    // in IDLE, response-side extension uses the latched request afterwards.
    assign align_size     = (state_reg == IDLE) ? dataE.msize        : size_reg;
    assign align_addr     = (state_reg == IDLE) ? dataE.aluout[2:0]  : addr_reg[2:0];
    assign align_unsigned = (state_reg == IDLE) ? dataE.mem_unsigned : unsigned_reg;

    mem_align #(
        .BUS_BYTES(BUS_BYTES)
    ) u_align (
        .msize         (align_size),
        .addr          (align_addr),
        .mem_unsigned  (align_unsigned),
        .writedata     (dataE.writedata),
        .rdata         (dresp.data),
        .strobe        (strobe),
        .wdata_shifted (wdata_shifted),
        .rdata_extended(rdata_extended),
        .aligned       (aligned)
    );

    always_comb begin
        loaded_m          = entry_reg;
        loaded_m.readdata = entry_reg.memread ? rdata_extended : entry_reg.readdata;
        misaligned_m          = to_mem(dataE, 64'd0);
        misaligned_m.regwrite = 1'b0;
    end

    always_comb begin
        dreq        = '0;
        dreq.valid  = (state_reg == WAIT);
        dreq.addr   = addr_reg;
        dreq.size   = size_reg;
        dreq.strobe = strobe_reg;
        dreq.data   = wdata_reg;
    end

    always_comb begin
        state_next = state_reg;
        mem_busy   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (memop && aligned) begin
                    state_next = WAIT;
                    mem_busy   = 1'b1;
                end
            end
            WAIT: begin
                // Releasing busy in the data_ok cycle lets upstream advance on the same edge.
                if (dresp.data_ok) begin
                    state_next = stallM ? HOLD : IDLE;
                    mem_busy   = stallM;
                end else begin
                    mem_busy   = 1'b1;
                end
            end
            HOLD: begin
                if (!stallM) begin
                    state_next = IDLE;
                end else begin
                    mem_busy   = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            data_m_reg   <= '0;
            misalign_reg <= 1'b0;
            addr_reg     <= '0;
            size_reg     <= MSIZE1;
            strobe_reg   <= '0;
            wdata_reg    <= '0;
            unsigned_reg <= 1'b0;
            entry_reg    <= '0;
            held_reg     <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (memop && aligned) begin
                        addr_reg     <= dataE.aluout;
                        size_reg     <= dataE.msize;
                        strobe_reg   <= strobe;
                        wdata_reg    <= wdata_shifted;
                        unsigned_reg <= dataE.mem_unsigned;
                        entry_reg    <= to_mem(dataE, 64'd0);
                    end
                    if (!stallM) begin
                        misalign_reg <= 1'b0;
                        if (flushM || !dataE.valid || (memop && aligned)) begin
                            data_m_reg   <= '0;
                        end else if (memop) begin
                            data_m_reg   <= misaligned_m;
                            misalign_reg <= 1'b1;
                        end else begin
                            data_m_reg   <= to_mem(dataE, 64'd0);
                        end
                    end
                end
                WAIT: begin
                    if (dresp.data_ok) begin
                        if (stallM) begin
                            held_reg     <= loaded_m;
                        end else begin
                            data_m_reg   <= loaded_m;
                            misalign_reg <= 1'b0;
                        end
                    end else if (!stallM) begin
                        // Keep writeback seeing bubbles while the access is in flight.
                        data_m_reg   <= '0;
                        misalign_reg <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!stallM) begin
                        data_m_reg   <= held_reg;
                        misalign_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dataM    = data_m_reg;
    assign misalign = misalign_reg;

endmodule
